uplink_frame_capture: RTL

UPLINK_FRAME_CAPTURE -- requirements
Module: uplink_frame_capture

---
 rtl/uplink_capture_pkg.sv | 23 ++
 rtl/uplink_frame_ram.sv | 28 ++
 rtl/uplink_frame_capture.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/uplink_capture_pkg.sv
// Shared constants, FSM state encoding and frame-to-word slicing for the uplink frame capture block.
package uplink_capture_pkg;

   localparam int UPLINK_W        = 234;
   localparam int WORDS_PER_FRAME = 8;
   localparam int WORD_W          = 32;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_RDY = 2'd1,
      CAPTURE  = 2'd2,
      READOUT  = 2'd3
   } state_e;

   // Word 7 carries the top 10 frame bits, zero-extended to 32.
   function automatic logic [WORD_W-1:0] frame_word(input logic [UPLINK_W-1:0] frame,
                                                    input logic [2:0]          idx);
      logic [WORDS_PER_FRAME*WORD_W-1:0] ext;
      ext = {{(WORDS_PER_FRAME*WORD_W-UPLINK_W){1'b0}}, frame};
      return ext[idx*WORD_W +: WORD_W];
   endfunction

endpackage

// File: rtl/uplink_frame_ram.sv
// Simple dual-port frame buffer, DEPTH x UPLINK_W, registered read with one cycle of latency.
module uplink_frame_ram
   import uplink_capture_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic                clk,
   input  logic                wr_en,
   input  logic [AW-1:0]       wr_addr,
   input  logic [UPLINK_W-1:0] wr_data,
   input  logic                rd_en,
   input  logic [AW-1:0]       rd_addr,
   output logic [UPLINK_W-1:0] rd_data
);

   logic [UPLINK_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/uplink_frame_capture.sv
// Captures N uplink frames into a buffer and streams them out as 32-bit words with valid/ready.
// Optional FEC drop filter: define UPLINK_CAPTURE_FEC_FILTER_EN.
module uplink_frame_capture
   import uplink_capture_pkg::*;
#(
   parameter int FRAME_DEPTH = 16
) (
   input  logic                clk40_i,
   input  logic                rst_i,
   input  logic                uplinkrdy_i,
   input  logic [UPLINK_W-1:0] uplinkUserData_i,
   input  logic                uplinkFEC_i,
   input  logic                arm_i,
   input  logic                abort_i,
   input  logic [8:0]          nframes_i,
   output logic [WORD_W-1:0]   rd_data_o,
   output logic                rd_valid_o,
   input  logic                rd_ready_i,
   output logic                rd_last_o,
   output logic                busy_o,
   output logic                done_o,
   output logic [8:0]          captured_o,
   output logic [15:0]         fec_drop_cnt_o
);

   localparam int         AW      = (FRAME_DEPTH > 1) ? $clog2(FRAME_DEPTH) : 1;
   localparam logic [8:0] DEPTH_N = 9'(FRAME_DEPTH);

   state_e              state;
   logic [8:0]          n_frames;
   logic [8:0]          captured;
   logic [8:0]          rd_frame;
   logic [8:0]          rd_next_frame;
   logic [8:0]          n_clamped;
   logic [2:0]          rd_word;
   logic                rd_valid;
   logic                done;
   logic                frame_seen;
   logic                fec_hit;
   logic                store;
   logic                accept;
   logic                last_word;
   logic                last_accept;
   logic                frame_adv;
   logic [UPLINK_W-1:0] ram_q;

   assign frame_seen = ((state == WAIT_RDY) || (state == CAPTURE)) && uplinkrdy_i && !abort_i;
   assign store      = frame_seen && !fec_hit;
   assign n_clamped  = ((nframes_i == 9'd0) || (nframes_i > DEPTH_N)) ? DEPTH_N : nframes_i;

   assign accept        = rd_valid && rd_ready_i;
   assign last_word     = (rd_word == 3'd7);
   assign rd_last_o     = rd_valid && last_word && (rd_frame == (n_frames - 9'd1));
   assign last_accept   = accept && rd_last_o;
   assign frame_adv     = accept && last_word;
   // Prefetch: address the next frame as soon as the last word of the current one is taken.
   assign rd_next_frame = frame_adv ? (rd_frame + 9'd1) : rd_frame;

   uplink_frame_ram #(
      .DEPTH (FRAME_DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk     (clk40_i),
      .wr_en   (store),
      .wr_addr (captured[AW-1:0]),
      .wr_data (uplinkUserData_i),
      .rd_en   (state == READOUT),
      .rd_addr (rd_next_frame[AW-1:0]),
      .rd_data (ram_q)
   );

   always_ff @(posedge clk40_i or posedge rst_i) begin
      if (rst_i) begin
         state    <= IDLE;
         n_frames <= 9'd0;
         captured <= 9'd0;
         rd_frame <= 9'd0;
         rd_word  <= 3'd0;
         rd_valid <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (abort_i) begin
            state    <= IDLE;
            rd_valid <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (arm_i) begin
                     n_frames <= n_clamped;
                     captured <= 9'd0;
                     state    <= WAIT_RDY;
                  end
               end
               WAIT_RDY, CAPTURE: begin
                  if (uplinkrdy_i) begin
                     state <= CAPTURE;
                  end
                  if (store) begin
                     captured <= captured + 9'd1;
                     if ((captured + 9'd1) == n_frames) begin
                        state    <= READOUT;
                        rd_frame <= 9'd0;
                        rd_word  <= 3'd0;
                     end
                  end
               end
               READOUT: begin
                  if (last_accept) begin
                     state    <= IDLE;
                     rd_valid <= 1'b0;
                     done     <= 1'b1;
                  end else begin
                     rd_valid <= 1'b1;
                     if (accept) begin
                        rd_word  <= rd_word + 3'd1;
                        rd_frame <= rd_next_frame;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

`ifdef UPLINK_CAPTURE_FEC_FILTER_EN
   logic [15:0] fec_cnt;

   assign fec_hit = uplinkFEC_i;

   always_ff @(posedge clk40_i or posedge rst_i) begin
      if (rst_i) begin
         fec_cnt <= 16'd0;
      end else if ((state == IDLE) && arm_i && !abort_i) begin
         fec_cnt <= 16'd0;
      end else if (frame_seen && uplinkFEC_i && (fec_cnt != 16'hFFFF)) begin
         fec_cnt <= fec_cnt + 16'd1;
      end
   end

   assign fec_drop_cnt_o = fec_cnt;
`else
   assign fec_hit        = uplinkFEC_i & 1'b0;
   assign fec_drop_cnt_o = 16'd0;
`endif

   assign rd_data_o  = rd_valid ? frame_word(ram_q, rd_word) : '0;
   assign rd_valid_o = rd_valid;
   assign busy_o     = (state != IDLE);
   assign done_o     = done;
   assign captured_o = captured;

endmodule
